// File: rtl/snake_pkg.sv
// Snake-game constants, spawn FSM state encoding and cell coordinate type.
// FOOD_SCAN_FALLBACK_EN adds the SCAN state used by food_spawn_ctrl.
package snake_pkg;
   localparam int GRID_W = 32;
   localparam int GRID_H = 24;
   localparam int X_BITS = 5;
   localparam int Y_BITS = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_QUERY,
      ST_CHECK
`ifdef FOOD_SCAN_FALLBACK_EN
      , ST_SCAN
`endif
   } spawn_state_t;

   typedef struct packed {
      logic [X_BITS-1:0] x;
      logic [Y_BITS-1:0] y;
   } cell_t;
endpackage

// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer: samples LFSR cells, checks occupancy, retries.
// Define FOOD_SCAN_FALLBACK_EN to raster-scan the board when random tries run out.
module food_spawn_ctrl #(
   parameter int GRID_W    = snake_pkg::GRID_W,
   parameter int GRID_H    = snake_pkg::GRID_H,
   parameter int X_BITS    = snake_pkg::X_BITS,
   parameter int Y_BITS    = snake_pkg::Y_BITS,
   parameter int MAX_TRIES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spawn_req,
   input  logic [15:0]       rnd,
   output logic              occ_query_valid,
   output logic [X_BITS-1:0] occ_query_x,
   output logic [Y_BITS-1:0] occ_query_y,
   input  logic              occ_hit,
   input  logic              food_eaten,
   output logic [X_BITS-1:0] food_x,
   output logic [Y_BITS-1:0] food_y,
   output logic              food_valid,
   output logic              busy,
   output logic              spawn_done,
   output logic              spawn_fail
);
   import snake_pkg::*;

   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   spawn_state_t      state, state_nxt;
   logic [X_BITS-1:0] cand_x, cand_x_nxt, food_x_nxt, rnd_x;
   logic [Y_BITS-1:0] cand_y, cand_y_nxt, food_y_nxt, rnd_y;
   logic [TRY_W-1:0]  tries, tries_nxt, tries_inc;
   logic              food_valid_nxt, done_nxt, fail_nxt;
   logic              rnd_in_grid, tries_spent;
   logic              unused_rnd;

   assign rnd_x       = rnd[X_BITS-1:0];
   assign rnd_y       = rnd[X_BITS+Y_BITS-1:X_BITS];
   assign unused_rnd  = ^rnd;
   assign rnd_in_grid = (32'(rnd_x) < GRID_W) && (32'(rnd_y) < GRID_H);
   assign tries_inc   = tries + 1'b1;
   assign tries_spent = 32'(tries_inc) >= MAX_TRIES;

`ifdef FOOD_SCAN_FALLBACK_EN
   localparam int CELLS  = GRID_W * GRID_H;
   localparam int SCAN_W = $clog2(CELLS + 1);
   localparam spawn_state_t EXHAUST_ST   = ST_SCAN;
   localparam logic         EXHAUST_FAIL = 1'b0;

   logic [SCAN_W-1:0] scanned, scanned_nxt, scanned_inc;
   logic              scanning, scanning_nxt, scan_wrap;
   logic [X_BITS-1:0] scan_x;
   logic [Y_BITS-1:0] scan_y, scan_y_inc;

   // raster step from the current candidate; a stale out-of-range y folds back to row 0
   assign scanned_inc = scanned + 1'b1;
   assign scan_wrap   = (32'(cand_x) + 1) >= GRID_W;
   assign scan_x      = scan_wrap ? '0 : cand_x + 1'b1;
   assign scan_y_inc  = scan_wrap ? cand_y + 1'b1 : cand_y;
   assign scan_y      = (32'(scan_y_inc) >= GRID_H) ? '0 : scan_y_inc;
`else
   localparam spawn_state_t EXHAUST_ST   = ST_IDLE;
   localparam logic         EXHAUST_FAIL = 1'b1;
`endif

   assign occ_query_valid = (state == ST_QUERY);
   assign occ_query_x     = cand_x;
   assign occ_query_y     = cand_y;
   assign busy            = (state != ST_IDLE);

   always_comb begin
      state_nxt      = state;
      cand_x_nxt     = cand_x;
      cand_y_nxt     = cand_y;
      tries_nxt      = tries;
      food_x_nxt     = food_x;
      food_y_nxt     = food_y;
      food_valid_nxt = food_valid & ~food_eaten;
      done_nxt       = 1'b0;
      fail_nxt       = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
      scanned_nxt    = scanned;
      scanning_nxt   = scanning;
`endif
      case (state)
         ST_IDLE: begin
            if (spawn_req) begin
               state_nxt      = ST_SAMPLE;
               tries_nxt      = '0;
               food_valid_nxt = 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
               scanned_nxt    = '0;
               scanning_nxt   = 1'b0;
`endif
            end
         end
         ST_SAMPLE: begin
            cand_x_nxt = rnd_x;
            cand_y_nxt = rnd_y;
            if (rnd_in_grid) begin
               state_nxt = ST_QUERY;
            end else begin
               tries_nxt = tries_inc;
               if (tries_spent) begin
                  state_nxt = EXHAUST_ST;
                  fail_nxt  = EXHAUST_FAIL;
               end
            end
         end
         ST_QUERY: state_nxt = ST_CHECK;
         ST_CHECK: begin
            // a success also overrides a same-cycle food_eaten
            if (!occ_hit) begin
               food_x_nxt     = cand_x;
               food_y_nxt     = cand_y;
               food_valid_nxt = 1'b1;
               done_nxt       = 1'b1;
               state_nxt      = ST_IDLE;
            end
`ifdef FOOD_SCAN_FALLBACK_EN
            else if (scanning) begin
               scanned_nxt = scanned_inc;
               if (32'(scanned_inc) >= CELLS) begin
                  fail_nxt  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  state_nxt = ST_SCAN;
               end
            end
`endif
            else begin
               tries_nxt = tries_inc;
               if (tries_spent) begin
                  state_nxt = EXHAUST_ST;
                  fail_nxt  = EXHAUST_FAIL;
               end else begin
                  state_nxt = ST_SAMPLE;
               end
            end
         end
`ifdef FOOD_SCAN_FALLBACK_EN
         ST_SCAN: begin
            cand_x_nxt   = scan_x;
            cand_y_nxt   = scan_y;
            scanning_nxt = 1'b1;
            state_nxt    = ST_QUERY;
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         tries      <= '0;
         food_x     <= '0;
         food_y     <= '0;
         food_valid <= 1'b0;
         spawn_done <= 1'b0;
         spawn_fail <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
         scanned    <= '0;
         scanning   <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         tries      <= tries_nxt;
         food_x     <= food_x_nxt;
         food_y     <= food_y_nxt;
         food_valid <= food_valid_nxt;
         spawn_done <= done_nxt;
         spawn_fail <= fail_nxt;
`ifdef FOOD_SCAN_FALLBACK_EN
         scanned    <= scanned_nxt;
         scanning   <= scanning_nxt;
`endif
      end
   end

   // candidate is only meaningful from SAMPLE onward, so it carries no reset
   always_ff @(posedge clk) begin
      cand_x <= cand_x_nxt;
      cand_y <= cand_y_nxt;
   end
endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Randomized bench for food_spawn_ctrl against a transaction-level placement model.
module tb_food_spawn_ctrl;
   localparam int GRID_W    = 32;
   localparam int GRID_H    = 24;
   localparam int MAX_TRIES = 16;
   localparam int NT        = 2600;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spawn_req = 1'b0;
   logic        occ_hit = 1'b0;
   logic        food_eaten = 1'b0;
   logic [15:0] rnd = '0;
   logic        occ_query_valid, food_valid, busy, spawn_done, spawn_fail;
   logic [4:0]  occ_query_x, occ_query_y, food_x, food_y;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] rtab [NT];
   bit          occ [32][32];
   int          eq_cyc[$], eq_x[$], eq_y[$];
   int          e_end, e_fx, e_fy;
   bit          e_ok;
   bit          ef, eaten_prev, q_prev;
   int          efx, efy, qx_prev, qy_prev, nq_obs;

   food_spawn_ctrl dut (
      .clk(clk), .rst(rst), .spawn_req(spawn_req), .rnd(rnd),
      .occ_query_valid(occ_query_valid), .occ_query_x(occ_query_x), .occ_query_y(occ_query_y),
      .occ_hit(occ_hit), .food_eaten(food_eaten), .food_x(food_x), .food_y(food_y),
      .food_valid(food_valid), .busy(busy), .spawn_done(spawn_done), .spawn_fail(spawn_fail)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic fill_occ(input int pct);
      for (int x = 0; x < 32; x++)
         for (int y = 0; y < 32; y++)
            occ[x][y] = (y >= GRID_H) || ($urandom_range(99) < pct);
   endtask

   task automatic fill_rnd(input bit in_range);
      for (int i = 0; i < NT; i++)
         rtab[i] = in_range ? {6'($urandom), 5'($urandom_range(GRID_H - 1)), 5'($urandom)}
                            : 16'($urandom);
   endtask

   task automatic fill_const(input logic [15:0] v);
      for (int i = 0; i < NT; i++) rtab[i] = v;
   endtask

   // Out of random tries at cycle s (first cycle after the failing step).
   task automatic model_exhaust(input int s, input int x, input int y);
`ifdef FOOD_SCAN_FALLBACK_EN
      for (int n = 0; n < GRID_W * GRID_H; n++) begin
         x = x + 1;
         if (x >= GRID_W) begin x = 0; y = y + 1; end
         if (y >= GRID_H) y = 0;
         eq_cyc.push_back(s + 1); eq_x.push_back(x); eq_y.push_back(y);
         if (!occ[x][y]) begin
            e_end = s + 3; e_ok = 1'b1; e_fx = x; e_fy = y;
            return;
         end
         s = s + 3;
      end
`endif
      e_end = s;
      e_ok  = 1'b0;
   endtask

   // Request is driven in cycle 0; cycle t is the one whose rnd the sampler sees.
   task automatic model_txn();
      int t, tries, x, y;
      eq_cyc.delete(); eq_x.delete(); eq_y.delete();
      t = 1;
      tries = 0;
      forever begin
         x = int'(rtab[t][4:0]);
         y = int'(rtab[t][9:5]);
         if (x >= GRID_W || y >= GRID_H) begin
            tries++;
            if (tries >= MAX_TRIES) begin model_exhaust(t + 1, x, y); return; end
            t++;
         end else begin
            eq_cyc.push_back(t + 1); eq_x.push_back(x); eq_y.push_back(y);
            if (!occ[x][y]) begin
               e_end = t + 3; e_ok = 1'b1; e_fx = x; e_fy = y;
               return;
            end
            tries++;
            if (tries >= MAX_TRIES) begin model_exhaust(t + 3, x, y); return; end
            t = t + 3;
         end
      end
   endtask

   task automatic run_txn(input bit noise);
      int qi;
      bit exp_q;
      model_txn();
      qi = 0;
      nq_obs = 0;
      for (int i = 0; i <= e_end + 1; i++) begin
         @(posedge clk);
         if (i == e_end && e_ok) begin ef = 1'b1; efx = e_fx; efy = e_fy; end
         else if (i == 1 || eaten_prev) ef = 1'b0;
         #1;
         rnd        = (i < NT) ? rtab[i] : 16'($urandom);
         spawn_req  = (i == 0) || (noise && i >= 1 && i < e_end && $urandom_range(3) == 0);
         food_eaten = noise && ($urandom_range(7) == 0);
         occ_hit    = q_prev ? occ[qx_prev][qy_prev] : 1'($urandom_range(1));
         eaten_prev = food_eaten;
         @(negedge clk);
         exp_q = (qi < eq_cyc.size()) && (eq_cyc[qi] == i);
         chk("query_valid", occ_query_valid, exp_q);
         if (exp_q) begin
            chk("query_x", occ_query_x, eq_x[qi]);
            chk("query_y", occ_query_y, eq_y[qi]);
            qi++;
         end
         if (occ_query_valid === 1'b1) nq_obs++;
         chk("busy", busy, (i >= 1 && i < e_end));
         chk("spawn_done", spawn_done, (i == e_end && e_ok));
         chk("spawn_fail", spawn_fail, (i == e_end && !e_ok));
         chk("food_valid", food_valid, ef);
         chk("food_x", food_x, efx);
         chk("food_y", food_y, efy);
         q_prev  = (occ_query_valid === 1'b1);
         qx_prev = int'(occ_query_x);
         qy_prev = int'(occ_query_y);
      end
      chk("query_count", nq_obs, eq_cyc.size());
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_qvalid"}, occ_query_valid, 0);
      chk({tag, "_done"}, spawn_done, 0);
      chk({tag, "_fail"}, spawn_fail, 0);
      chk({tag, "_fvalid"}, food_valid, 0);
      chk({tag, "_fx"}, food_x, 0);
      chk({tag, "_fy"}, food_y, 0);
   endtask

   task automatic clear_expect();
      ef = 1'b0; efx = 0; efy = 0; eaten_prev = 1'b0; q_prev = 1'b0;
   endtask

   initial begin
      clear_expect();
      @(posedge clk); #1;
      chk_reset_outputs("reset");
      @(posedge clk); #2;
      rst = 1'b0;

      // single free cell request, rnd=0x0143 -> (3,10)
      fill_occ(0); fill_const(16'h0143);
      run_txn(1'b0);
      chk("t1_nq", nq_obs, 1);
      chk("t1_fx", food_x, 3);
      chk("t1_fy", food_y, 10);
      chk("t1_fvalid", food_valid, 1);

      // out-of-range (0,31) first, then (3,10)
      fill_const(16'h0143); rtab[1] = 16'h03E0;
      run_txn(1'b0);
      chk("t2_nq", nq_obs, 1);
      chk("t2_fx", food_x, 3);
      chk("t2_fy", food_y, 10);

      // first candidate occupied, second (5,4) free
      fill_occ(0); occ[3][10] = 1'b1;
      fill_const(16'h0085); rtab[1] = 16'h0143;
      run_txn(1'b0);
      chk("t3_nq", nq_obs, 2);
      chk("t3_fx", food_x, 5);
      chk("t3_fy", food_y, 4);

      // board full, every sample in range
      fill_occ(100); fill_rnd(1'b1);
      run_txn(1'b0);
      chk("t4_fvalid", food_valid, 0);
`ifndef FOOD_SCAN_FALLBACK_EN
      chk("t4_nq", nq_obs, MAX_TRIES);
`endif

      // only (0,0) free
      fill_occ(100); occ[0][0] = 1'b0; fill_rnd(1'b1);
      run_txn(1'b0);

      for (int k = 0; k < 40; k++) begin
         fill_occ((k % 4) * 33);
         fill_rnd(k[0]);
         run_txn(1'b1);
      end

      // reset while in CHECK, with a second request issued while busy
      fill_occ(0); fill_const(16'h0143);
      @(posedge clk); #1;
      spawn_req = 1'b1; rnd = 16'h0143; food_eaten = 1'b0; occ_hit = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      spawn_req = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_busy", busy, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_outputs("mid_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", spawn_done, 0);
      chk("post_rst_busy", busy, 0);
      @(negedge clk);
      chk("post_rst_done2", spawn_done, 0);
      chk("post_rst_fail", spawn_fail, 0);
      clear_expect();

      fill_occ(0); fill_const(16'h0143);
      run_txn(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
